// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcodes, access sizes, FSM states
// and small decode helpers.
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mstate_e;

  function automatic size_e decode_size(input logic [5:0] op);
    size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_B;
      OP_LH, OP_LHU, OP_SH: sz = SZ_H;
      OP_LW, OP_SW:         sz = SZ_W;
      default:              sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_signed_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_align.sv
// Combinational size decode, alignment check, store lane steering and
// load byte/half extraction with sign or zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  size_e       size_s;
  logic        sign_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Decode size and pick the addressed lane out of the load word
  always_comb begin
    size_s = decode_size(opcode);
    sign_s = is_signed_load(opcode);
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
  end

  // Alignment, byte enables, replicated store data and extended load value
  always_comb begin
    aligned  = 1'b1;
    be       = 4'b1111;
    wdata    = store_data;
    load_val = rdata;
    case (size_s)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
        if (sign_s) begin
          load_val = {{24{byte_s[7]}}, byte_s};
        end else begin
          load_val = {24'd0, byte_s};
        end
      end
      SZ_H: begin
        aligned = (addr_lo[0] == 1'b0);
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{store_data[15:0]}};
        if (sign_s) begin
          load_val = {{16{half_s[15]}}, half_s};
        end else begin
          load_val = {16'd0, half_s};
        end
      end
      SZ_W: begin
        aligned = (addr_lo == 2'b00);
      end
      default: begin
        aligned = (addr_lo == 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues data-memory accesses, stalls upstream while waiting,
// times out hung accesses and produces the MEM/WB register and forwarding triple.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] aluResult1_PR,
  input  logic [31:0] readDataB1_PR,
  input  logic [31:0] Instr1_PR,
  input  logic [4:0]  writeRegister1_PR,
  input  logic        do_writeback1_PR,
  input  logic        MemRead1_PR,
  input  logic        MemWrite1_PR,
  input  logic        MemtoReg1_PR,
  mem_stage_if.master dmem,
  output logic        STALL_MEM,
  output logic [31:0] Data1_MEM,
  output logic [4:0]  writeRegister1_MEM,
  output logic        do_writeback1_MEM,
  output logic [31:0] Data1_WB,
  output logic [4:0]  writeRegister1_WB,
  output logic        do_writeback1_WB,
  output logic        ADDR_ERR,
  output logic        BUS_ERR
);

  mstate_e     state_r;
  mstate_e     state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic        aligned_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] load_val_s;
  logic        access_s;
  logic        mem_op_s;
  logic        mis_s;
  logic        timeout_hit_s;
  logic        stall_s;
  logic        unused_instr_s;

  assign unused_instr_s = ^Instr1_PR[25:0];

  mem_align u_align (
    .opcode     (Instr1_PR[31:26]),
    .addr_lo    (aluResult1_PR[1:0]),
    .store_data (readDataB1_PR),
    .rdata      (dmem.dmem_rdata),
    .aligned    (aligned_s),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_val   (load_val_s)
  );

  assign access_s = MemRead1_PR | MemWrite1_PR;
  assign mem_op_s = access_s & aligned_s;
  assign mis_s    = access_s & ~aligned_s;

  // Request fields follow the EXE/MEM register, which upstream holds while stalled
  assign dmem.dmem_req   = mem_op_s & ~RESET;
  assign dmem.dmem_we    = MemWrite1_PR;
  assign dmem.dmem_addr  = {aluResult1_PR[31:2], 2'b00};
  assign dmem.dmem_be    = MemWrite1_PR ? be_s : 4'b0000;
  assign dmem.dmem_wdata = wdata_s;

  assign STALL_MEM          = stall_s;
  assign Data1_MEM          = aluResult1_PR;
  assign writeRegister1_MEM = writeRegister1_PR;
  assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= M_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; a late ready always beats the timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      M_IDLE: begin
        if (mem_op_s && !dmem.dmem_ready) begin
          state_nxt_s = M_WAIT;
        end else begin
          state_nxt_s = M_IDLE;
        end
      end
      M_WAIT: begin
        if (!mem_op_s || dmem.dmem_ready || timeout_hit_s) begin
          state_nxt_s = M_IDLE;
        end else begin
          state_nxt_s = M_WAIT;
        end
      end
      default: state_nxt_s = M_IDLE;
    endcase
  end

  // FSM outputs: timeout detection and upstream stall
  always_comb begin
    timeout_hit_s = 1'b0;
    stall_s       = 1'b0;
    if (state_r == M_WAIT) begin
      timeout_hit_s = mem_op_s & ~dmem.dmem_ready & (cnt_r == CNT_W'(TIMEOUT - 1));
    end else begin
      timeout_hit_s = 1'b0;
    end
    stall_s = mem_op_s & ~dmem.dmem_ready & ~timeout_hit_s & ~RESET;
  end

  // Wait counter: 1 on entry to M_WAIT, counts up while waiting
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= '0;
    end else if (state_nxt_s == M_WAIT) begin
      cnt_r <= (state_r == M_IDLE) ? CNT_W'(1) : cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // MEM/WB register and single-cycle error pulses
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Data1_WB          <= 32'd0;
      writeRegister1_WB <= 5'd0;
      do_writeback1_WB  <= 1'b0;
      ADDR_ERR          <= 1'b0;
      BUS_ERR           <= 1'b0;
    end else if (stall_s) begin
      do_writeback1_WB  <= 1'b0;
      ADDR_ERR          <= 1'b0;
      BUS_ERR           <= 1'b0;
    end else begin
      Data1_WB          <= MemtoReg1_PR ? load_val_s : aluResult1_PR;
      writeRegister1_WB <= writeRegister1_PR;
      do_writeback1_WB  <= do_writeback1_PR & ~mis_s & ~timeout_hit_s;
      ADDR_ERR          <= mis_s;
      BUS_ERR           <= timeout_hit_s;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] aluResult1_PR;
  logic [31:0] readDataB1_PR;
  logic [31:0] Instr1_PR;
  logic [4:0]  writeRegister1_PR;
  logic        do_writeback1_PR;
  logic        MemRead1_PR;
  logic        MemWrite1_PR;
  logic        MemtoReg1_PR;
  logic        STALL_MEM;
  logic [31:0] Data1_MEM;
  logic [4:0]  writeRegister1_MEM;
  logic        do_writeback1_MEM;
  logic [31:0] Data1_WB;
  logic [4:0]  writeRegister1_WB;
  logic        do_writeback1_WB;
  logic        ADDR_ERR;
  logic        BUS_ERR;

  int total = 0;
  int bad   = 0;
  int stall_n;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .aluResult1_PR      (aluResult1_PR),
    .readDataB1_PR      (readDataB1_PR),
    .Instr1_PR          (Instr1_PR),
    .writeRegister1_PR  (writeRegister1_PR),
    .do_writeback1_PR   (do_writeback1_PR),
    .MemRead1_PR        (MemRead1_PR),
    .MemWrite1_PR       (MemWrite1_PR),
    .MemtoReg1_PR       (MemtoReg1_PR),
    .dmem               (bus),
    .STALL_MEM          (STALL_MEM),
    .Data1_MEM          (Data1_MEM),
    .writeRegister1_MEM (writeRegister1_MEM),
    .do_writeback1_MEM  (do_writeback1_MEM),
    .Data1_WB           (Data1_WB),
    .writeRegister1_WB  (writeRegister1_WB),
    .do_writeback1_WB   (do_writeback1_WB),
    .ADDR_ERR           (ADDR_ERR),
    .BUS_ERR            (BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] b,
                        input logic rd, input logic wr, input logic m2r,
                        input logic [4:0] wreg, input logic dowb);
    Instr1_PR         = {op, 26'd0};
    aluResult1_PR     = addr;
    readDataB1_PR     = b;
    MemRead1_PR       = rd;
    MemWrite1_PR      = wr;
    MemtoReg1_PR      = m2r;
    writeRegister1_PR = wreg;
    do_writeback1_PR  = dowb;
  endtask

  initial begin
    RESET = 1'b1;
    set_op(6'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;
    tick();
    tick();
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, STALL_MEM}, 32'd0);
    chk("rst_wb_data", Data1_WB, 32'd0);
    chk("rst_wb_en", {31'd0, do_writeback1_WB}, 32'd0);
    chk("rst_errs", {30'd0, ADDR_ERR, BUS_ERR}, 32'd0);
    RESET = 1'b0;
    tick();

    // LW 0x100 zero-wait
    set_op(OP_LW, 32'h100, 32'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("lw_stall", {31'd0, STALL_MEM}, 32'd0);
    chk("lw_addr", bus.dmem_addr, 32'h100);
    chk("lw_fwd_en", {31'd0, do_writeback1_MEM}, 32'd0);
    tick();
    chk("lw_wb_data", Data1_WB, 32'hDEADBEEF);
    chk("lw_wb_en", {31'd0, do_writeback1_WB}, 32'd1);
    chk("lw_wb_reg", {27'd0, writeRegister1_WB}, 32'd3);

    // LB / LBU 0x103, LH 0x100, LHU 0x102
    set_op(OP_LB, 32'h103, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
    bus.dmem_rdata = 32'h80000000;
    tick();
    chk("lb_wb_data", Data1_WB, 32'hFFFFFF80);
    set_op(OP_LBU, 32'h103, 32'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
    tick();
    chk("lbu_wb_data", Data1_WB, 32'h00000080);
    set_op(OP_LH, 32'h100, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    bus.dmem_rdata = 32'h12348765;
    tick();
    chk("lh_wb_data", Data1_WB, 32'hFFFF8765);
    set_op(OP_LHU, 32'h102, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    bus.dmem_rdata = 32'h80010000;
    tick();
    chk("lhu_wb_data", Data1_WB, 32'h00008001);

    // SB 0x201 zero-wait
    set_op(OP_SB, 32'h201, 32'h000000A5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    chk("sb_be", {28'd0, bus.dmem_be}, 32'h2);
    chk("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
    chk("sb_we", {31'd0, bus.dmem_we}, 32'd1);
    tick();

    // ALU op with ready high and no request
    set_op(6'h00, 32'h55, 32'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
    #1;
    chk("alu_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("alu_fwd", Data1_MEM, 32'h55);
    chk("alu_fwd_en", {31'd0, do_writeback1_MEM}, 32'd1);
    tick();
    chk("alu_wb_data", Data1_WB, 32'h55);
    chk("alu_wb_en", {31'd0, do_writeback1_WB}, 32'd1);

    // SH 0x202 with ready after 3 cycles
    set_op(OP_SH, 32'h202, 32'h00001234, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    bus.dmem_ready = 1'b0;
    stall_n = 0;
    #1;
    chk("sh_be", {28'd0, bus.dmem_be}, 32'hC);
    chk("sh_wdata", bus.dmem_wdata, 32'h12341234);
    if (STALL_MEM) stall_n++;
    tick();
    chk("sh_bubble_en", {31'd0, do_writeback1_WB}, 32'd0);
    chk("sh_hold_data", Data1_WB, 32'h55);
    chk("sh_hold_reg", {27'd0, writeRegister1_WB}, 32'd7);
    chk("sh_req_held", {31'd0, bus.dmem_req}, 32'd1);
    if (STALL_MEM) stall_n++;
    tick();
    if (STALL_MEM) stall_n++;
    tick();
    bus.dmem_ready = 1'b1;
    #1;
    chk("sh_stall_cycles", stall_n, 32'd3);
    chk("sh_stall_release", {31'd0, STALL_MEM}, 32'd0);
    tick();
    chk("sh_wb_data", Data1_WB, 32'h202);

    // Misaligned LW 0x101
    set_op(OP_LW, 32'h101, 32'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1);
    bus.dmem_ready = 1'b0;
    #1;
    chk("mis_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, STALL_MEM}, 32'd0);
    tick();
    chk("mis_addr_err", {31'd0, ADDR_ERR}, 32'd1);
    chk("mis_wb_en", {31'd0, do_writeback1_WB}, 32'd0);
    set_op(6'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("mis_pulse_end", {31'd0, ADDR_ERR}, 32'd0);

    // LW 0x300 never ready -> timeout
    set_op(OP_LW, 32'h300, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1);
    stall_n = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!STALL_MEM) break;
      stall_n++;
      tick();
    end
    chk("to_stall_cycles", stall_n, 32'd15);
    chk("to_no_early_err", {31'd0, BUS_ERR}, 32'd0);
    tick();
    chk("to_bus_err", {31'd0, BUS_ERR}, 32'd1);
    chk("to_wb_en", {31'd0, do_writeback1_WB}, 32'd0);
    set_op(6'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("to_pulse_end", {31'd0, BUS_ERR}, 32'd0);

    // LW 0x400, ready arrives on the timeout cycle: ready wins
    set_op(OP_LW, 32'h400, 32'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("race_stall", {31'd0, STALL_MEM}, 32'd0);
    tick();
    chk("race_no_err", {31'd0, BUS_ERR}, 32'd0);
    chk("race_wb_data", Data1_WB, 32'hCAFEF00D);
    chk("race_wb_en", {31'd0, do_writeback1_WB}, 32'd1);
    bus.dmem_ready = 1'b0;

    // RESET while waiting on LW 0x500
    set_op(OP_LW, 32'h500, 32'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b1);
    tick();
    tick();
    RESET = 1'b1;
    #1;
    chk("rw_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rw_stall", {31'd0, STALL_MEM}, 32'd0);
    tick();
    chk("rw_wb_data", Data1_WB, 32'd0);
    chk("rw_wb_en", {31'd0, do_writeback1_WB}, 32'd0);
    chk("rw_errs", {30'd0, ADDR_ERR, BUS_ERR}, 32'd0);
    RESET = 1'b0;
    // Fresh access must start from a clean counter: full 15-cycle stall again
    set_op(OP_LW, 32'h600, 32'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b1);
    stall_n = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!STALL_MEM) break;
      stall_n++;
      tick();
    end
    chk("rw_restart_stall", stall_n, 32'd15);
    tick();
    chk("rw_restart_err", {31'd0, BUS_ERR}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
